// File: rtl/hgcal_fc_pkg.sv
// Shared constants and the command word type for the HGCAL fast-control encoder.
`timescale 1ns/1ps
package hgcal_fc_pkg;

    localparam int HGCAL_FC_CMD_W = 8;
    localparam logic [HGCAL_FC_CMD_W-1:0] HGCAL_FC_IDLE = 8'hAC;

    typedef logic [HGCAL_FC_CMD_W-1:0] hgcal_fc_cmd_t;

endpackage

// File: rtl/hgcal_fc_cmd_fifo.sv
// Per-channel synchronous command FIFO; full/empty come from registered occupancy.
`timescale 1ns/1ps
module hgcal_fc_cmd_fifo
    import hgcal_fc_pkg::*;
#(
    parameter int WIDTH = HGCAL_FC_CMD_W,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/hgcal_fast_control_encoder.sv
// Multi-channel fast-control encoder: per-channel command FIFOs, IDLE fill,
// broadcast preemption and BX phase realignment, serialised MSB first.
`timescale 1ns/1ps
module hgcal_fast_control_encoder
    import hgcal_fc_pkg::*;
#(
    parameter int               NUM_CH     = 4,
    parameter int               CMD_W      = HGCAL_FC_CMD_W,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [CMD_W-1:0] IDLE_CMD   = CMD_W'(HGCAL_FC_IDLE)
) (
    input  logic                    clk320,
    input  logic                    reset,
    input  logic                    bx_sync,
    input  logic [NUM_CH*CMD_W-1:0] cmd_data,
    input  logic [NUM_CH-1:0]       cmd_valid,
    output logic [NUM_CH-1:0]       cmd_ready,
    input  logic [CMD_W-1:0]        bcast_data,
    input  logic                    bcast_valid,
    output logic [NUM_CH-1:0]       fc_elink,
    output logic                    bx_strobe,
    output logic [NUM_CH-1:0]       overflow
);

    localparam int PH_W = (CMD_W > 1) ? $clog2(CMD_W) : 1;

    logic [PH_W-1:0]   phase_q, phase_d;
    logic              load;
    logic [NUM_CH-1:0] full, empty, push, pop;
    logic [NUM_CH-1:0] overflow_q, overflow_d;
    logic [CMD_W-1:0]  head [NUM_CH];
    logic [CMD_W-1:0]  sr_q [NUM_CH];
    logic [CMD_W-1:0]  sr_d [NUM_CH];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        hgcal_fc_cmd_fifo #(
            .WIDTH (CMD_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk320),
            .reset     (reset),
            .push      (push[c]),
            .push_data (cmd_data[c*CMD_W +: CMD_W]),
            .pop       (pop[c]),
            .head      (head[c]),
            .full      (full[c]),
            .empty     (empty[c])
        );
    end

    // A load ends the current BX: either the natural last bit or a forced realignment.
    always_comb begin
        load       = (phase_q == PH_W'(CMD_W-1)) | bx_sync;
        phase_d    = load ? '0 : phase_q + PH_W'(1);
        push       = cmd_valid & ~full;
        overflow_d = overflow_q | (cmd_valid & full);
        pop        = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sr_d[c] = sr_q[c] << 1;
            if (load) begin
                if (bcast_valid) begin
                    sr_d[c] = bcast_data;
                end else if (!empty[c]) begin
                    sr_d[c] = head[c];
                    pop[c]  = 1'b1;
                end else begin
                    sr_d[c] = IDLE_CMD;
                end
            end
        end
    end

    always_ff @(posedge clk320) begin
        if (reset) begin
            phase_q    <= '0;
            overflow_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sr_q[c] <= IDLE_CMD;
            end
        end else begin
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
            for (int c = 0; c < NUM_CH; c++) begin
                sr_q[c] <= sr_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            fc_elink[c] = sr_q[c][CMD_W-1];
        end
        bx_strobe = (phase_q == '0);
        cmd_ready = ~full;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_hgcal_fast_control_encoder.sv
// Scoreboard bench: stimulus queues expected words per channel tagged with their BX,
// a monitor reassembles each serial word and compares it (IDLE when nothing is due).
`timescale 1ns/1ps
module tb_hgcal_fast_control_encoder;

    localparam int NUM_CH = 4;
    localparam int CMD_W  = 8;
    localparam logic [7:0] IDLE = 8'hAC;

    logic                    clk320 = 1'b0;
    logic                    reset;
    logic                    bx_sync;
    logic [NUM_CH*CMD_W-1:0] cmd_data;
    logic [NUM_CH-1:0]       cmd_valid;
    logic [NUM_CH-1:0]       cmd_ready;
    logic [CMD_W-1:0]        bcast_data;
    logic                    bcast_valid;
    logic [NUM_CH-1:0]       fc_elink;
    logic                    bx_strobe;
    logic [NUM_CH-1:0]       overflow;

    hgcal_fast_control_encoder #(
        .NUM_CH     (NUM_CH),
        .CMD_W      (CMD_W),
        .FIFO_DEPTH (8),
        .IDLE_CMD   (IDLE)
    ) dut (
        .clk320      (clk320),
        .reset       (reset),
        .bx_sync     (bx_sync),
        .cmd_data    (cmd_data),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .bcast_data  (bcast_data),
        .bcast_valid (bcast_valid),
        .fc_elink    (fc_elink),
        .bx_strobe   (bx_strobe),
        .overflow    (overflow)
    );

    always #2 clk320 = ~clk320;

    typedef struct {
        int         bx;
        logic [7:0] w;
    } exp_t;

    exp_t       exp_q [NUM_CH][$];
    int         n_vec = 0;
    int         n_bad = 0;
    int         bx_cnt = 0;
    int         cur_phase = 0;
    int         bitcnt = 0;
    bit         mon_en = 1'b0;
    bit         allow_short = 1'b1;
    logic [7:0] shreg [NUM_CH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input int c, input int bx, input logic [7:0] w);
        exp_t e;
        e.bx = bx;
        e.w  = w;
        exp_q[c].push_back(e);
    endtask

    task automatic finalize(input int idx);
        logic [7:0] want;
        for (int c = 0; c < NUM_CH; c++) begin
            while (exp_q[c].size() > 0 && exp_q[c][0].bx < idx) begin
                n_vec++;
                n_bad++;
                $display("FAIL missed_word ch%0d: word %h due at bx %0d never seen",
                         c, exp_q[c][0].w, exp_q[c][0].bx);
                void'(exp_q[c].pop_front());
            end
            want = IDLE;
            if (exp_q[c].size() > 0 && exp_q[c][0].bx == idx) begin
                want = exp_q[c][0].w;
                void'(exp_q[c].pop_front());
            end
            check($sformatf("ch%0d_bx%0d", c, idx), 32'(shreg[c]), 32'(want));
        end
    endtask

    // Monitor: samples on the falling edge, one bit per cycle.
    always @(negedge clk320) begin
        if (!mon_en) begin
            bitcnt = 0;
        end else if (bx_strobe === 1'b1) begin
            if (bitcnt == CMD_W) finalize(bx_cnt);
            else if (!allow_short) check("strobe_period", 32'(bitcnt), 32'(CMD_W));
            bx_cnt++;
            cur_phase = 0;
            bitcnt    = 1;
            for (int c = 0; c < NUM_CH; c++) shreg[c] = {7'b0, fc_elink[c]};
        end else begin
            if (bitcnt >= CMD_W) check("strobe_period", 32'(bitcnt + 1), 32'(CMD_W));
            cur_phase++;
            bitcnt++;
            for (int c = 0; c < NUM_CH; c++) shreg[c] = {shreg[c][6:0], fc_elink[c]};
        end
    end

    task automatic next_cycle();
        @(negedge clk320);
        #1;
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            if (cur_phase == p) return;
        end
        n_vec++;
        n_bad++;
        $display("FAIL wait_phase%0d: phase never reached, last phase %0d", p, cur_phase);
    endtask

    initial begin
        int k;
        reset       = 1'b1;
        bx_sync     = 1'b0;
        cmd_data    = '0;
        cmd_valid   = '0;
        bcast_data  = '0;
        bcast_valid = 1'b0;

        // Reset and idle
        repeat (2) @(posedge clk320);
        #1 mon_en = 1'b1;
        next_cycle();
        check("rst_cmd_ready", 32'(cmd_ready), 32'hF);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_bx_strobe", 32'(bx_strobe), 32'h1);
        check("rst_fc_elink", 32'(fc_elink), 32'hF);
        reset       = 1'b0;
        allow_short = 1'b0;
        repeat (3 * CMD_W) next_cycle();

        // Single command on channel 2, accepted at phase 3
        wait_phase(3);
        k = bx_cnt;
        cmd_data[23:16] = 8'h5A;
        cmd_valid       = 4'b0100;
        expect_word(2, k + 1, 8'h5A);
        next_cycle();
        cmd_valid = '0;
        repeat (3 * CMD_W) next_cycle();

        // Fill / overflow on channel 0, first write at phase 7 of an idle BX
        wait_phase(7);
        k = bx_cnt;
        cmd_valid = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            cmd_data[7:0] = 8'(i + 1);
            expect_word(0, k + 2 + i, 8'(i + 1));
            next_cycle();
        end
        check("fill_ready_low", 32'(cmd_ready[0]), 32'h0);
        cmd_data[7:0] = 8'h09;
        next_cycle();
        cmd_valid = '0;
        check("fill_overflow", 32'(overflow), 32'h1);
        check("fill_ready_back", 32'(cmd_ready[0]), 32'h1);
        repeat (10 * CMD_W) next_cycle();

        // Broadcast preempts channel 1's queued word
        wait_phase(2);
        k = bx_cnt;
        cmd_data[15:8] = 8'h11;
        cmd_valid      = 4'b0010;
        next_cycle();
        cmd_valid = '0;
        wait_phase(6);
        bcast_data  = 8'hF0;
        bcast_valid = 1'b1;
        wait_phase(0);
        bcast_valid = 1'b0;
        for (int c = 0; c < NUM_CH; c++) expect_word(c, k + 1, 8'hF0);
        expect_word(1, k + 2, 8'h11);
        repeat (3 * CMD_W) next_cycle();

        // bx_sync at phase 4 pulls a queued word forward immediately
        wait_phase(1);
        k = bx_cnt;
        cmd_data[7:0] = 8'h3C;
        cmd_valid     = 4'b0001;
        expect_word(0, k + 1, 8'h3C);
        next_cycle();
        cmd_valid = '0;
        wait_phase(4);
        allow_short = 1'b1;
        bx_sync     = 1'b1;
        next_cycle();
        bx_sync = 1'b0;
        check("sync_strobe", 32'(bx_strobe), 32'h1);
        check("sync_msb", 32'(fc_elink), 32'hE);
        allow_short = 1'b0;
        repeat (3 * CMD_W) next_cycle();

        // Reset with three words queued on channel 3 and overflow[0] still set
        wait_phase(0);
        cmd_valid = 4'b1000;
        cmd_data[31:24] = 8'hAA;
        next_cycle();
        cmd_data[31:24] = 8'hBB;
        next_cycle();
        cmd_data[31:24] = 8'hCC;
        next_cycle();
        cmd_valid = '0;
        wait_phase(4);
        allow_short = 1'b1;
        reset       = 1'b1;
        repeat (2) next_cycle();
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'hF);
        check("mid_rst_overflow", 32'(overflow), 32'h0);
        check("mid_rst_strobe", 32'(bx_strobe), 32'h1);
        check("mid_rst_fc_elink", 32'(fc_elink), 32'hF);
        reset       = 1'b0;
        allow_short = 1'b0;
        repeat (4 * CMD_W + 2) next_cycle();

        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("pending_ch%0d", c), 32'(exp_q[c].size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
